cu_param: RTL and testbench

Parametrised control unit for the Harvard CPU. It fetches instructions from program memory, sequences multi-word instructions through a fixed state machine, drives the external combinational ALU, and accesses data memory over a valid/ready handshake with separate read and write buses. Relative to the first-generation control unit it adds:
- configurable data, address and register-file widths
- asynchronous reset
- stall on slow data memory
- correct skipping of the branch target word when a branch is not taken
- HLT instruction
- sticky illegal-opcode flag

---
 rtl/cu_param.sv | 206 ++++++++++++++++++++
 tb/tb_cu_param.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_param.sv
// Parametrised Harvard CPU control unit: fetch/decode/operand sequencing, external ALU drive,
// and a valid/ready data-memory port with stall support.
module cu_param #(
    parameter int unsigned DW   = 8,
    parameter int unsigned AW   = 8,
    parameter int unsigned NREG = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [AW-1:0] addr_program,
    input  logic [DW-1:0] data_program,
    output logic [7:0]    ins_alu,
    output logic [DW-1:0] in1,
    output logic [DW-1:0] in2,
    input  logic [DW-1:0] result,
    output logic          mem_valid,
    output logic          mem_we,
    output logic [AW-1:0] addr_memory,
    output logic [DW-1:0] wdata_memory,
    input  logic [DW-1:0] rdata_memory,
    input  logic          mem_ready,
    output logic          halted,
    output logic          illegal
);

    localparam int unsigned RW = $clog2(NREG);
    localparam int unsigned BW = $clog2(DW);

    localparam logic [DW-1:0] OpNop   = DW'(8'h00);
    localparam logic [DW-1:0] OpAdd   = DW'(8'h01);
    localparam logic [DW-1:0] OpSub   = DW'(8'h02);
    localparam logic [DW-1:0] OpMovRR = DW'(8'h03);
    localparam logic [DW-1:0] OpMovRM = DW'(8'h04);
    localparam logic [DW-1:0] OpMovMR = DW'(8'h05);
    localparam logic [DW-1:0] OpMovI  = DW'(8'h06);
    localparam logic [DW-1:0] OpJmp   = DW'(8'h07);
    localparam logic [DW-1:0] OpJb    = DW'(8'h08);
    localparam logic [DW-1:0] OpJnb   = DW'(8'h09);
    localparam logic [DW-1:0] OpHlt   = DW'(8'h0A);
    localparam logic [DW-1:0] OpClr   = DW'(8'h12);

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StOp1,
        StOp2,
        StMemw,
        StRetire,
        StHalt
    } state_e;

    state_e        state;
    logic [DW-1:0] cir;
    logic [DW-1:0] w1;
    logic [DW-1:0] mdata;
    logic [DW-1:0] gpr [NREG];

    logic [RW-1:0] a_dp;
    logic [RW-1:0] b_dp;
    logic [RW-1:0] b_w1;
    logic [BW-1:0] bit_idx;
    logic          bit_set;
    logic          br_taken;

    // Register fields of the word currently on the program bus, and of the latched w1.
    assign a_dp     = data_program[4 +: RW];
    assign b_dp     = data_program[RW-1:0];
    assign b_w1     = w1[RW-1:0];
    assign bit_idx  = BW'(a_dp);
    assign bit_set  = gpr[b_dp][bit_idx];
    assign br_taken = (cir == OpJb) ? bit_set : !bit_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StFetch;
            addr_program <= '0;
            ins_alu      <= '0;
            in1          <= '0;
            in2          <= '0;
            mem_valid    <= 1'b0;
            mem_we       <= 1'b0;
            addr_memory  <= '0;
            wdata_memory <= '0;
            halted       <= 1'b0;
            illegal      <= 1'b0;
            cir          <= '0;
            w1           <= '0;
            mdata        <= '0;
            for (int i = 0; i < NREG; i++) begin
                gpr[i] <= '0;
            end
        end else begin
            unique case (state)
                StFetch: begin
                    cir   <= data_program;
                    state <= StDecode;
                end
                StDecode: begin
                    case (cir)
                        OpNop: state <= StRetire;
                        OpClr: begin
                            gpr[0] <= '0;
                            state  <= StRetire;
                        end
                        OpHlt: begin
                            halted <= 1'b1;
                            state  <= StHalt;
                        end
                        OpAdd, OpSub, OpMovRR, OpMovRM, OpMovMR, OpMovI, OpJmp, OpJb,
                        OpJnb: begin
                            addr_program <= addr_program + AW'(1);
                            state        <= StOp1;
                        end
                        default: begin
                            illegal <= 1'b1;
                            state   <= StRetire;
                        end
                    endcase
                end
                StOp1: begin
                    w1 <= data_program;
                    case (cir)
                        OpMovRR: begin
                            gpr[b_dp] <= gpr[a_dp];
                            state     <= StRetire;
                        end
                        OpJmp: begin
                            addr_program <= data_program[AW-1:0];
                            state        <= StFetch;
                        end
                        OpAdd, OpSub: begin
                            ins_alu <= cir[7:0];
                            in1     <= gpr[0];
                            in2     <= gpr[b_dp];
                            state   <= StOp2;
                        end
                        OpJb, OpJnb: begin
                            // Not taken retires directly, so RETIRE's increment skips w2.
                            addr_program <= addr_program + AW'(1);
                            state        <= br_taken ? StOp2 : StRetire;
                        end
                        OpMovMR: begin
                            mem_valid   <= 1'b1;
                            mem_we      <= 1'b0;
                            addr_memory <= data_program[AW-1:0];
                            state       <= StMemw;
                        end
                        default: begin
                            addr_program <= addr_program + AW'(1);
                            state        <= StOp2;
                        end
                    endcase
                end
                StOp2: begin
                    case (cir)
                        OpAdd, OpSub: begin
                            gpr[0] <= result;
                            state  <= StRetire;
                        end
                        OpMovI: begin
                            gpr[b_dp] <= w1;
                            state     <= StRetire;
                        end
                        OpMovMR: begin
                            gpr[b_dp] <= mdata;
                            state     <= StRetire;
                        end
                        OpMovRM: begin
                            mem_valid    <= 1'b1;
                            mem_we       <= 1'b1;
                            addr_memory  <= data_program[AW-1:0];
                            wdata_memory <= gpr[b_w1];
                            state        <= StMemw;
                        end
                        OpJb, OpJnb: begin
                            addr_program <= data_program[AW-1:0];
                            state        <= StFetch;
                        end
                        default: state <= StRetire;
                    endcase
                end
                StMemw: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        if (mem_we) begin
                            state <= StRetire;
                        end else begin
                            mdata        <= rdata_memory;
                            addr_program <= addr_program + AW'(1);
                            state        <= StOp2;
                        end
                    end
                end
                StRetire: begin
                    addr_program <= addr_program + AW'(1);
                    in1          <= '0;
                    ins_alu      <= '0;
                    state        <= StFetch;
                end
                StHalt: state <= StHalt;
                default: state <= StFetch;
            endcase
        end
    end

endmodule

// File: tb/tb_cu_param.sv
// Self-checking bench for cu_param: directed cases plus a randomized instruction stream
// compared against an instruction-level reference model.
module tb_cu_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] addr_program, data_program, ins_alu, in1, in2, result;
    logic       mem_valid, mem_we, mem_ready, halted, illegal;
    logic [7:0] addr_memory, wdata_memory, rdata_memory;

    logic [7:0] pmem [256];
    logic [7:0] dmem [256];

    // Narrow-address instance for PC wrap.
    logic       rst4_n;
    logic [3:0] addr4, addr_mem4;
    logic [7:0] data4, ins4, i1_4, i2_4, wd4;
    logic       v4, we4, h4, il4;
    logic [7:0] pmem4 [16];

    // Instruction-level model state.
    logic [7:0] m_pc;
    logic [7:0] m_gpr [4];
    logic [7:0] m_dmem [256];
    logic       m_ill;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    assign data_program = pmem[addr_program];
    assign rdata_memory = dmem[addr_memory];
    assign result = (ins_alu == 8'd1) ? in1 + in2 : (ins_alu == 8'd2) ? in1 - in2 : 8'h00;
    assign data4 = pmem4[addr4];

    cu_param #(.DW(8), .AW(8), .NREG(4)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .addr_program (addr_program),
        .data_program (data_program),
        .ins_alu      (ins_alu),
        .in1          (in1),
        .in2          (in2),
        .result       (result),
        .mem_valid    (mem_valid),
        .mem_we       (mem_we),
        .addr_memory  (addr_memory),
        .wdata_memory (wdata_memory),
        .rdata_memory (rdata_memory),
        .mem_ready    (mem_ready),
        .halted       (halted),
        .illegal      (illegal)
    );

    cu_param #(.DW(8), .AW(4), .NREG(4)) u_dut4 (
        .clk          (clk),
        .rst_n        (rst4_n),
        .addr_program (addr4),
        .data_program (data4),
        .ins_alu      (ins4),
        .in1          (i1_4),
        .in2          (i2_4),
        .result       (8'h00),
        .mem_valid    (v4),
        .mem_we       (we4),
        .addr_memory  (addr_mem4),
        .wdata_memory (wd4),
        .rdata_memory (8'h00),
        .mem_ready    (1'b1),
        .halted       (h4),
        .illegal      (il4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc  = 8'h00;
        m_ill = 1'b0;
        for (int i = 0; i < 4; i++) m_gpr[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Places one instruction at the model PC, predicts its effect, runs it and checks it.
    task automatic run_insn(input logic [7:0] op, input logic [7:0] o1, input logic [7:0] o2,
                            input int waits);
        int         cyc, wcnt, nvalid;
        logic [7:0] npc, p1, p2, e_in1, e_in2, e_addr, e_wdata;
        logic       is_alu, is_mem, exp_we, bitv, taken;
        logic [1:0] a1, b1, b2;
        p1 = m_pc + 8'd1;
        p2 = m_pc + 8'd2;
        pmem[m_pc] = op;
        pmem[p1]   = o1;
        pmem[p2]   = o2;
        a1 = o1[5:4];
        b1 = o1[1:0];
        b2 = o2[1:0];
        is_alu = 1'b0;
        is_mem = 1'b0;
        exp_we = 1'b0;
        e_in1 = 8'h00;
        e_in2 = 8'h00;
        e_addr = 8'h00;
        e_wdata = 8'h00;
        case (op)
            8'h00: begin cyc = 3; npc = m_pc + 8'd1; end
            8'h01, 8'h02: begin
                cyc = 5; npc = m_pc + 8'd2; is_alu = 1'b1;
                e_in1 = m_gpr[0]; e_in2 = m_gpr[b1];
                m_gpr[0] = (op == 8'h01) ? e_in1 + e_in2 : e_in1 - e_in2;
            end
            8'h03: begin cyc = 4; npc = m_pc + 8'd2; m_gpr[b1] = m_gpr[a1]; end
            8'h04: begin
                cyc = 6 + waits; npc = m_pc + 8'd3; is_mem = 1'b1; exp_we = 1'b1;
                e_addr = o2; e_wdata = m_gpr[b1]; m_dmem[o2] = e_wdata;
            end
            8'h05: begin
                cyc = 6 + waits; npc = m_pc + 8'd3; is_mem = 1'b1;
                e_addr = o1; m_gpr[b2] = m_dmem[o1];
            end
            8'h06: begin cyc = 5; npc = m_pc + 8'd3; m_gpr[b2] = o1; end
            8'h07: begin cyc = 3; npc = o1; end
            8'h08, 8'h09: begin
                bitv  = m_gpr[b1][a1];
                taken = (op == 8'h08) ? bitv : !bitv;
                cyc = 4; npc = taken ? o2 : m_pc + 8'd3;
            end
            8'h12: begin cyc = 3; npc = m_pc + 8'd1; m_gpr[0] = 8'h00; end
            default: begin cyc = 3; npc = m_pc + 8'd1; m_ill = 1'b1; end
        endcase
        wcnt = waits;
        nvalid = 0;
        for (int c = 0; c < cyc; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (is_alu && c == 2) begin
                check("alu_in1", in1, e_in1);
                check("alu_in2", in2, e_in2);
                check("alu_op", ins_alu, op);
            end
            if (mem_valid) begin
                nvalid++;
                check("mem_addr", addr_memory, e_addr);
                check("mem_we", mem_we, exp_we);
                if (exp_we) check("mem_wdata", wdata_memory, e_wdata);
                if (wcnt == 0) begin
                    mem_ready = 1'b1;
                    if (mem_we) dmem[addr_memory] = wdata_memory;
                end else begin
                    mem_ready = 1'b0;
                    wcnt--;
                end
            end else begin
                mem_ready = 1'b0;
            end
        end
        m_pc = npc;
        check("pc", addr_program, m_pc);
        check("illegal", illegal, m_ill);
        check("alu_idle", ins_alu, 8'h00);
        check("valid_idle", mem_valid, 1'b0);
        check("mem_cycles", nvalid, is_mem ? waits + 1 : 0);
    endtask

    initial begin
        logic [7:0] op, o1, o2;
        int         r;
        for (int i = 0; i < 256; i++) begin
            pmem[i]   = 8'h00;
            dmem[i]   = 8'($urandom);
            m_dmem[i] = dmem[i];
        end
        for (int i = 0; i < 16; i++) pmem4[i] = 8'h00;
        pmem4[0] = 8'h07;
        pmem4[1] = 8'h0F;

        rst_n     = 1'b0;
        rst4_n    = 1'b0;
        mem_ready = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_pc", addr_program, 8'h00);
        check("rst_ins_alu", ins_alu, 8'h00);
        check("rst_in1", in1, 8'h00);
        check("rst_in2", in2, 8'h00);
        check("rst_valid", mem_valid, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_maddr", addr_memory, 8'h00);
        check("rst_wdata", wdata_memory, 8'h00);
        check("rst_halted", halted, 1'b0);
        check("rst_illegal", illegal, 1'b0);

        // JMP 0xF then NOP at 0xF must wrap a 4-bit PC to 0.
        rst4_n = 1'b1;
        repeat (3) @(negedge clk);
        check("aw4_jmp", addr4, 4'hF);
        repeat (3) @(negedge clk);
        check("aw4_wrap", addr4, 4'h0);
        check("aw4_valid", v4, 1'b0);
        check("aw4_halt", h4, 1'b0);

        do_reset();
        run_insn(8'h00, 8'h00, 8'h00, 0);
        rst_n = 1'b0;
        #1;
        check("async_rst_pc", addr_program, 8'h00);

        // Reset while a write is stalled in MEMW.
        do_reset();
        pmem[0] = 8'h04;
        pmem[1] = 8'h00;
        pmem[2] = 8'h10;
        repeat (4) @(negedge clk);
        check("memw_valid", mem_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("memw_rst_valid", mem_valid, 1'b0);
        check("memw_rst_pc", addr_program, 8'h00);

        do_reset();
        run_insn(8'h06, 8'h05, 8'h00, 0);
        run_insn(8'h06, 8'h03, 8'h01, 0);
        run_insn(8'h02, 8'h01, 8'h00, 0);
        run_insn(8'h04, 8'h00, 8'h40, 0);
        run_insn(8'h06, 8'hAA, 8'h02, 0);
        run_insn(8'h04, 8'h02, 8'h10, 3);
        run_insn(8'h05, 8'h10, 8'h03, 2);
        run_insn(8'h04, 8'h03, 8'h50, 0);
        run_insn(8'h06, 8'h04, 8'h01, 0);
        run_insn(8'h08, 8'h21, 8'h20, 0);
        run_insn(8'h09, 8'h21, 8'h30, 0);
        run_insn(8'h33, 8'h00, 8'h00, 0);
        run_insn(8'h00, 8'h00, 8'h00, 0);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 11);
            if (r <= 9) op = 8'(r);
            else if (r == 10) op = 8'h12;
            else op = 8'(8'h13 + $urandom_range(0, 8'hEC));
            o1 = 8'($urandom);
            o2 = 8'($urandom);
            run_insn(op, o1, o2, $urandom_range(0, 3));
        end

        pmem[m_pc] = 8'h0A;
        repeat (3) @(negedge clk);
        check("halted", halted, 1'b1);
        check("halt_pc", addr_program, m_pc);
        repeat (5) @(negedge clk);
        check("halt_hold", halted, 1'b1);
        check("halt_pc_frozen", addr_program, m_pc);
        check("halt_valid", mem_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
